// File: rtl/ntt_pkg.sv
// Shared definitions for the matrix-vector NTT engine.
//   W_DEF/Q_DEF/NINV_DEF : default coefficient width, modulus and M^-1 mod Q
//   coeff_t              : coefficient type at the default width
//   state_t              : control FSM encoding
//   mod_mul              : (a*b) mod q, used by the MAC lanes and the final scaling
package ntt_pkg;

  localparam int W_DEF    = 12;
  localparam int Q_DEF    = 3329;
  localparam int NINV_DEF = 3303;

  typedef logic [W_DEF-1:0] coeff_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINAL,
    S_DONE
  } state_t;

  // Operands travel as 32-bit values so the function serves any W <= 32.
  // The product is fully reduced, so the result is always < q.
  function automatic logic [31:0] mod_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] q);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return 32'(p % {32'd0, q});
  endfunction

endpackage

// File: rtl/ntt_mac_lane.sv
// One serial multiply-accumulate lane.
//   clk, rst : clock, asynchronous active-high reset
//   a, t     : coefficient and twiddle for the current column
//   mul_en   : capture (a*t mod Q) into the product register
//   acc_en   : add the product register into the accumulator (mod Q)
//   clr      : zero the accumulator (wins over acc_en)
//   acc      : running dot product, always < Q
module ntt_mac_lane import ntt_pkg::*; #(
  parameter int W = W_DEF,
  parameter int Q = Q_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] t,
  input  logic         mul_en,
  input  logic         acc_en,
  input  logic         clr,
  output logic [W-1:0] acc
);

  logic [W-1:0] prod;
  logic [W:0]   sum;

  // Both terms are < Q, so one conditional subtraction fully reduces.
  always_comb sum = {1'b0, acc} + {1'b0, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_en) prod <= W'(mod_mul(32'(a), 32'(t), 32'(Q)));
      if (clr)
        acc <= '0;
      else if (acc_en)
        acc <= (sum >= (W+1)'(Q)) ? W'(sum - (W+1)'(Q)) : W'(sum);
    end
  end

endmodule

// File: rtl/ntt_matvec.sv
// Matrix-vector NTT engine: LANES serial MAC lanes share one twiddle word per
// cycle. Lane l computes row r of the dot product over coeff_i[LANES*k+l] and
// writes coeff_o[LANES*r+l].
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : start pulse, only honoured in IDLE
//   inverse_i    : mode (1 = inverse, bank 1 + NINV scaling), sampled on start
//   coeff_i      : input polynomial, held stable while busy_o
//   tw_addr_o    : {bank, row, col} twiddle ROM address
//   tw_data_i    : ROM word for the address of the previous cycle
//   busy_o       : run in progress (IDLE excluded)
//   done_o       : one-cycle completion pulse
//   coeff_o      : registered result, updated row by row
// M = N/LANES must be at least 2.
module ntt_matvec import ntt_pkg::*; #(
  parameter  int N     = 256,
  parameter  int W     = W_DEF,
  parameter  int Q     = Q_DEF,
  parameter  int LANES = 2,
  parameter  int NINV  = NINV_DEF,
  localparam int M     = N / LANES,
  localparam int AW    = $clog2(M),
  localparam int TAW   = 1 + 2 * AW
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           inverse_i,
  input  logic [W-1:0]   coeff_i [0:N-1],
  output logic [TAW-1:0] tw_addr_o,
  input  logic [W-1:0]   tw_data_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [W-1:0]   coeff_o [0:N-1]
);

  localparam int STAGES = 1;
  localparam int IW     = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(M - 1);

  state_t state, state_n;

  logic          mode;
  logic [AW-1:0] row, col, col_d1;
  logic          drain_cnt;
  logic          clr_acc;
  // vld_pipe[0]: tw_data_i valid (multiply); vld_pipe[1]: product valid (accumulate)
  logic [STAGES:0] vld_pipe;

  logic [LANES-1:0][W-1:0] lane_a, lane_acc, lane_res;
  logic [N-1:0][W-1:0]     out_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    clr_acc = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_ISSUE;
          clr_acc = 1'b1;
        end
      end
      S_ISSUE: if (col == LAST) state_n = S_DRAIN;
      S_DRAIN: if (drain_cnt)   state_n = S_FINAL;
      S_FINAL: begin
        clr_acc = 1'b1;
        state_n = (row == LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- counters, pipe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode      <= 1'b0;
      row       <= '0;
      col       <= '0;
      col_d1    <= '0;
      drain_cnt <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      // col_d1 names the column whose twiddle is on tw_data_i this cycle
      col_d1   <= col;
      vld_pipe <= {vld_pipe[STAGES-1:0], state == S_ISSUE};
      case (state)
        S_IDLE: begin
          if (start_i) begin
            mode <= inverse_i;
            row  <= '0;
            col  <= '0;
          end
        end
        S_ISSUE: begin
          drain_cnt <= 1'b0;
          if (col != LAST) col <= col + 1'b1;
        end
        S_DRAIN: drain_cnt <= 1'b1;
        S_FINAL: begin
          col <= '0;
          if (row != LAST) row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------- datapath
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l]   = coeff_i[IW'(int'(col_d1) * LANES + l)];
      lane_res[l] = mode ? W'(mod_mul(32'(lane_acc[l]), 32'(NINV), 32'(Q)))
                         : lane_acc[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ntt_mac_lane #(.W(W), .Q(Q)) u_lane (
      .clk    (clk_i),
      .rst    (rst_i),
      .a      (lane_a[l]),
      .t      (tw_data_i),
      .mul_en (vld_pipe[0]),
      .acc_en (vld_pipe[1]),
      .clr    (clr_acc),
      .acc    (lane_acc[l])
    );
  end

  // Writeback: during FINAL the LANES outputs of the current row are loaded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
    end else if (state == S_FINAL) begin
      for (int i = 0; i < N; i++)
        if (row == AW'(i / LANES)) out_q[i] <= lane_res[i % LANES];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) coeff_o[i] = out_q[i];
  end

  assign tw_addr_o = {mode, row, col};
  assign busy_o    = (state != S_IDLE);
  assign done_o    = (state == S_DONE);

endmodule

// File: tb/tb_ntt_matvec.sv
module tb_ntt_matvec;

  localparam int N = 256;
  localparam int W = 12;
  localparam int LAT2 = 128 * 131 + 1;  // 16769
  localparam int LAT4 = 64 * 67 + 1;    // 4289
  localparam int ROM_IDENT = 0;         // both banks identity
  localparam int ROM_ONES  = 1;         // bank0 all ones, bank1 junk (7)
  localparam int ROM_INV   = 2;         // bank0 all ones, bank1 identity

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LANES=2 instance
  logic          start2 = 1'b0, inv2 = 1'b0;
  logic [W-1:0]  cin2  [0:N-1];
  logic [W-1:0]  cout2 [0:N-1];
  logic [14:0]   tw_addr2;
  logic [W-1:0]  tw_data2 = '0;
  logic          busy2, done2;

  // LANES=4 instance
  logic          start4 = 1'b0, inv4 = 1'b0;
  logic [W-1:0]  cin4  [0:N-1];
  logic [W-1:0]  cout4 [0:N-1];
  logic [12:0]   tw_addr4;
  logic [W-1:0]  tw_data4 = '0;
  logic          busy4, done4;

  int rom_kind = ROM_IDENT;
  int checks = 0;
  int errors = 0;

  ntt_matvec #(.N(N), .W(W), .LANES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .inverse_i(inv2),
    .coeff_i(cin2), .tw_addr_o(tw_addr2), .tw_data_i(tw_data2),
    .busy_o(busy2), .done_o(done2), .coeff_o(cout2)
  );

  ntt_matvec #(.N(N), .W(W), .LANES(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .inverse_i(inv4),
    .coeff_i(cin4), .tw_addr_o(tw_addr4), .tw_data_i(tw_data4),
    .busy_o(busy4), .done_o(done4), .coeff_o(cout4)
  );

  function automatic logic [W-1:0] rom_word(input int kind, input logic bank,
                                             input int r, input int c);
    logic [W-1:0] id;
    id = (r == c) ? 12'd1 : 12'd0;
    case (kind)
      ROM_IDENT: return id;
      ROM_ONES:  return bank ? 12'd7 : 12'd1;
      default:   return bank ? id : 12'd1;
    endcase
  endfunction

  // External ROMs, one cycle of read latency
  always @(posedge clk)
    tw_data2 <= rom_word(rom_kind, tw_addr2[14], int'(tw_addr2[13:7]), int'(tw_addr2[6:0]));
  always @(posedge clk)
    tw_data4 <= rom_word(ROM_IDENT, tw_addr4[12], int'(tw_addr4[11:6]), int'(tw_addr4[5:0]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run2(input string name, input bit inv, input bit poke);
    int lat, bank_bad;
    bit seen;
    lat = 0; bank_bad = 0; seen = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b1; inv2 = inv;
    while (!seen && lat < LAT2 + 50) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      lat++;
      if (lat == 1) check({name, "_busy_after_start"}, busy2, 1);
      if (poke && lat == 1000) start2 = 1'b1;
      if (busy2 && tw_addr2[14] !== inv) bank_bad++;
      if (done2) seen = 1'b1;
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_done_latency"}, lat, LAT2);
    check({name, "_bank_bit_errors"}, bank_bad, 0);
    if (poke) start2 = 1'b1;  // lands on the done_o cycle, must be ignored
    @(posedge clk); #1;
    start2 = 1'b0;
    check({name, "_done_one_cycle"}, done2, 0);
    check({name, "_idle_after_done"}, busy2, 0);
    @(posedge clk); #1;
    check({name, "_no_restart"}, busy2, 0);
  endtask

  typedef struct {
    string name;
    bit    inv;
    int    rom;
    bit    ramp;   // 1: coeff_i[i]=i, expect coeff_o[i]=i
    int    val;    // constant input when ramp=0
    int    exp;    // constant expectation when ramp=0
    bit    poke;   // extra start pulses mid-run and on the done cycle
  } vec_t;

  vec_t vecs[4];

  initial begin
    int nz;
    vecs[0] = '{"ident_fwd_ramp", 1'b0, ROM_IDENT, 1'b1, 0,    0,    1'b0};
    vecs[1] = '{"ones_fwd_1",     1'b0, ROM_ONES,  1'b0, 1,    128,  1'b0};
    vecs[2] = '{"ones_fwd_3328",  1'b0, ROM_ONES,  1'b0, 3328, 3201, 1'b1};
    vecs[3] = '{"ident_inv_128",  1'b1, ROM_INV,   1'b0, 128,  1,    1'b1};

    for (int i = 0; i < N; i++) begin
      cin2[i] = W'(i);
      cin4[i] = W'(i * 13);
    end

    // Reset state
    #12;
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_tw_addr", tw_addr2, 0);
    nz = 0;
    for (int i = 0; i < N; i++) if (cout2[i] !== '0) nz++;
    check("rst_coeff_nonzero", nz, 0);
    @(negedge clk); rst = 1'b0;

    // Start a forward identity run, then reset it while in row 5
    rom_kind = ROM_IDENT;
    @(posedge clk); #1; start2 = 1'b1; inv2 = 1'b0;
    @(posedge clk); #1; start2 = 1'b0;
    repeat (5 * 131 + 3) @(posedge clk);
    #1;
    check("midrun_row4_written", cout2[9], 9);
    check("midrun_busy", busy2, 1);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", busy2, 0);
    check("abort_done", done2, 0);
    check("abort_tw_addr", tw_addr2, 0);
    nz = 0;
    for (int i = 0; i < N; i++) if (cout2[i] !== '0) nz++;
    check("abort_coeff_nonzero", nz, 0);
    @(negedge clk); rst = 1'b0;

    // Table-driven full runs (first one doubles as the post-reset run)
    for (int v = 0; v < 4; v++) begin
      rom_kind = vecs[v].rom;
      for (int i = 0; i < N; i++)
        cin2[i] = vecs[v].ramp ? W'(i) : W'(vecs[v].val);
      run2(vecs[v].name, vecs[v].inv, vecs[v].poke);
      for (int i = 0; i < N; i++)
        check($sformatf("%s_coeff[%0d]", vecs[v].name, i), cout2[i],
              vecs[v].ramp ? i : vecs[v].exp);
    end

    // LANES=4 forward identity run
    begin
      int lat;
      bit seen;
      lat = 0; seen = 1'b0;
      @(posedge clk); #1; start4 = 1'b1;
      while (!seen && lat < LAT4 + 50) begin
        @(posedge clk); #1;
        start4 = 1'b0;
        lat++;
        if (done4) seen = 1'b1;
      end
      check("l4_done_seen", seen, 1);
      check("l4_done_latency", lat, LAT4);
      for (int i = 0; i < N; i++)
        check($sformatf("l4_coeff[%0d]", i), cout4[i], (i * 13));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_matvec.md
# ntt_matvec

Parametrised matrix-vector NTT engine: the generalised successor of the fixed two-lane, 256-point dot-product NTT. It computes a forward or inverse NTT as LANES parallel serial multiply-accumulate lanes. Each lane streams one twiddle entry per cycle from an external twiddle ROM. It sits in the same polynomial-arithmetic datapath, between the coefficient register file and the downstream pointwise-multiply stage.

## Interface
Parameters:
- N, 256: coefficients per polynomial; must be a multiple of LANES.
- W, 12: coefficient width.
- Q, 3329: modulus; all values on coeff_o lie in [0, Q).
- LANES, 2: parallel MAC lanes; M = N/LANES is the dot-product length and the row count.
- NINV, 3303: M^-1 mod Q, applied in inverse mode.

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- clk_i, in, 1: clock.
- rst_i, in, 1: asynchronous active-high reset.
- start_i, in, 1: one-cycle start pulse; accepted only in IDLE.
- inverse_i, in, 1: mode select (0 forward, 1 inverse); sampled on an accepted start.
- coeff_i [0:N-1], in, W each: input polynomial; must be held stable while busy_o=1.
- tw_addr_o, out, 1+2*clog2(M): {bank, row, col}; bank=inverse.
- tw_data_i, in, W: ROM entry for the address issued on the previous cycle (fixed 1-cycle latency).
- busy_o, out, 1: high from the cycle after an accepted start until the cycle done_o pulses.
- done_o, out, 1: one-cycle completion pulse.
- coeff_o [0:N-1], out, W each: registered result.

## Operation
- Lane l computes, for each row r, the dot product of sub-vector a_l[k] = coeff_i[LANES*k + l] (k = 0..M-1) with ROM row r. The result is written to coeff_o[LANES*r + l].
- All lanes share one ROM word per cycle.
- Each MAC step computes acc = (acc + (a*t mod Q)) mod Q:
  - the 2W-bit product is fully reduced before accumulation;
  - the accumulator is W bits and always < Q.
- Inverse mode reads bank 1 and multiplies each final accumulator by NINV mod Q before writeback. Forward mode writes the accumulator unchanged.
- FSM states and transitions:
  - IDLE: on start_i, latch mode, clear row and column counters, clear accumulators, go to ISSUE.
  - ISSUE: drive col 0..M-1 on successive cycles; after col M-1 go to DRAIN.
  - DRAIN: 2 cycles to flush the ROM-latency and multiply stages.
  - FINAL: 1 cycle; optional NINV scaling, write LANES results, clear accumulators, row++. If row was M-1 go to DONE, else go to ISSUE.
  - DONE: 1 cycle; done_o=1; return to IDLE.
- start_i is ignored in every state except IDLE.
- coeff_o holds its last value until overwritten row by row by the next run; it is not cleared at start.
- Reset values: coeff_o all 0, busy_o 0, done_o 0, tw_addr_o 0, FSM in IDLE.
- Reset mid-operation aborts immediately to those values; no partial done_o.

## Timing
- Per row: M (ISSUE) + 2 (DRAIN) + 1 (FINAL) = M+3 cycles.
- done_o asserts exactly M*(M+3)+1 cycles after the start-accept edge; for N=256, LANES=2 this is 16769.
- Row r results become visible on coeff_o the cycle after that row's FINAL.
- Counter wrap: col and row counters saturate at M-1 and never wrap inside a run. The bank bit is constant for the whole run.
- start_i asserted in the same cycle as done_o is ignored (FSM is not in IDLE); a run may be started on the following cycle.
- Back-to-back runs are therefore separated by at least one IDLE cycle.

## Structure
- Shared package ntt_pkg holds:
  - Q, NINV, W defaults;
  - a coeff_t typedef (logic [W-1:0]);
  - the FSM state enum;
  - a mod_mul function used by both MAC and scaling.
- One sub-module, ntt_mac_lane: a registered multiply, reduce and accumulate unit with clear/enable.
  - It is instantiated LANES times via generate.
  - The top module owns the FSM, counters, ROM addressing and writeback.

## Test plan
- Reset: assert rst_i mid-run (row 5) -> busy_o, done_o, coeff_o all 0 within the same cycle; next start runs to completion normally.
- Identity ROM, forward, coeff_i[i] = i -> coeff_o[i] = i for all i; done_o at exactly cycle 16769 after start.
- All-ones ROM bank 0, coeff_i all 1 -> every coeff_o = 128.
- All-ones ROM bank 0, coeff_i all 3328 -> every coeff_o = (128*3328) mod 3329 = 3201.
- Inverse, identity bank 1, coeff_i all 128 -> every coeff_o = 1; tw_addr_o bank bit = 1 throughout.
- start_i pulsed mid-run and on the done_o cycle -> ignored, no restart. LANES=4, N=256 with identity ROM -> coeff_o = coeff_i, done_o after 64*67+1 = 4289 cycles.
